// File: rtl/gray_code_counter.sv
// gray_code_counter: registered N-bit up/down counter with binary and Gray outputs.
// Optional macro GRAY_CHECK_EN adds a sticky gray_err output.
module gray_code_counter #(
    parameter int N    = 4,
    parameter bit WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] bin_out,
    output logic [N-1:0] gray_out,
    output logic         tc,
    output logic         sat
`ifdef GRAY_CHECK_EN
    ,
    output logic         gray_err
`endif
);
    localparam logic [N-1:0] ONES = {N{1'b1}};
    logic [N-1:0] bin_q, bin_d, gray_q, gray_d, step_val;
    logic         tc_q, tc_d, sat_q, sat_d, at_lim, reach, moved;
    // next state: load beats count; a step off either end wraps or holds depending on WRAP
    always_comb begin
        at_lim   = up_dn ? (bin_q == ONES) : (bin_q == '0);
        step_val = up_dn ? bin_q + 1'b1 : bin_q - 1'b1;
        reach    = up_dn ? (step_val == ONES) : (step_val == '0);
        moved    = !load && en && (WRAP || !at_lim);
        bin_d    = load ? load_val : (moved ? step_val : bin_q);
        gray_d   = bin_d ^ (bin_d >> 1);
        tc_d     = moved && (WRAP ? at_lim : reach);
        sat_d    = WRAP ? 1'b0 :
                   load ? (load_val == '0 || load_val == ONES) :
                   en   ? (at_lim || reach) : sat_q;
    end
    // Gray has its own register so the port is never decoded combinationally
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
            sat_q  <= sat_d;
        end
    end
    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign tc       = tc_q;
    assign sat      = sat_q;
`ifdef GRAY_CHECK_EN
    logic [N-1:0] gray_prev_q, gray_prev_d;
    logic         step_q, step_d, err_q, err_d;
    // sticky: a count step must flip exactly one Gray bit, and Gray must always match binary
    always_comb begin
        gray_prev_d = gray_q;
        step_d      = moved;
        err_d       = err_q || (gray_q != (bin_q ^ (bin_q >> 1))) ||
                      (step_q && !$onehot(gray_q ^ gray_prev_q));
    end
    // previous Gray value and step marker line up with the cycle being checked
    always_ff @(posedge clk) begin
        if (rst) begin
            gray_prev_q <= '0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            gray_prev_q <= gray_prev_d;
            step_q      <= step_d;
            err_q       <= err_d;
        end
    end
    assign gray_err = err_q;
`endif
endmodule

// File: tb/tb_gray_code_counter.sv
// tb_gray_code_counter: directed plus random checks of a saturating and a wrapping counter
module tb_gray_code_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, up_dn = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] bin [2];
    logic [3:0] gray[2];
    logic       tc  [2];
    logic       sat [2];
    int         total = 0, bad = 0;
    int         mb[2];
    bit         mt[2], ms[2], mstep[2];
    logic [3:0] pg[2];
`ifdef GRAY_CHECK_EN
    logic       gerr[2];
    logic [3:0] fg;
`endif

    always #5 clk = ~clk;

    gray_code_counter #(.N(4), .WRAP(1'b0)) u0 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .bin_out(bin[0]), .gray_out(gray[0]), .tc(tc[0]), .sat(sat[0])
`ifdef GRAY_CHECK_EN
        , .gray_err(gerr[0])
`endif
    );
    gray_code_counter #(.N(4), .WRAP(1'b1)) u1 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
        .bin_out(bin[1]), .gray_out(gray[1]), .tc(tc[1]), .sat(sat[1])
`ifdef GRAY_CHECK_EN
        , .gray_err(gerr[1])
`endif
    );

    task automatic chk(string tag, int w, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[w%0d] observed=%0h expected=%0h", tag, w, obs, exp);
        end
    endtask

    // index 0 saturates, index 1 wraps; range is 0..15 in plain integers
    task automatic model();
        int nb;
        for (int w = 0; w < 2; w++) begin
            mstep[w] = 0;
            if (rst) begin
                mb[w] = 0; mt[w] = 0; ms[w] = 0;
            end else if (load) begin
                mb[w] = int'(load_val); mt[w] = 0;
                ms[w] = (w == 0) && (load_val == 0 || load_val == 15);
            end else if (en) begin
                nb = mb[w] + (up_dn ? 1 : -1);
                if (nb < 0 || nb > 15) begin
                    if (w == 1) begin
                        mb[w] = (nb + 16) % 16; mt[w] = 1; mstep[w] = 1;
                    end else begin
                        mt[w] = 0; ms[w] = 1;
                    end
                end else begin
                    mb[w] = nb; mstep[w] = 1;
                    mt[w] = (w == 0) && (nb == 0 || nb == 15);
                    ms[w] = mt[w];
                end
            end else mt[w] = 0;
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [3:0] lv, input logic e, input logic u);
        logic [3:0] eb;
        rst = r; load = l; load_val = lv; en = e; up_dn = u;
        pg[0] = gray[0]; pg[1] = gray[1];
        @(posedge clk);
        #1;
        model();
        for (int w = 0; w < 2; w++) begin
            eb = 4'(mb[w]);
            chk("bin", w, 32'(bin[w]), 32'(eb));
            chk("gray", w, 32'(gray[w]), 32'(eb ^ (eb >> 1)));
            chk("tc", w, 32'(tc[w]), 32'(mt[w]));
            chk("sat", w, 32'(sat[w]), 32'(ms[w]));
            if (mstep[w]) chk("onebit", w, 32'($countones(gray[w] ^ pg[w])), 32'd1);
`ifdef GRAY_CHECK_EN
            chk("gerr_clean", w, 32'(gerr[w]), 32'd0);
`endif
        end
    endtask

    initial begin
        step(1, 1, 4'hA, 1, 1);
        step(1, 1, 4'hA, 1, 1);
        chk("reset_bin", 1, 32'(bin[1]), 32'd0);
        chk("reset_tc", 1, 32'(tc[1]), 32'd0);
        step(0, 0, 4'h0, 0, 1);
        repeat (15) step(0, 0, 4'h0, 1, 1);
        chk("sweep_gray15", 1, 32'(gray[1]), 32'b1000);
        step(0, 0, 4'h0, 1, 1);
        chk("sweep_wrap_tc", 1, 32'(tc[1]), 32'd1);
        chk("sweep_wrap_bin", 1, 32'(bin[1]), 32'd0);
        step(0, 1, 4'h1, 0, 0);
        step(0, 0, 4'h0, 1, 0);
        step(0, 0, 4'h0, 1, 0);
        chk("down_wrap_bin", 1, 32'(bin[1]), 32'd15);
        chk("down_wrap_tc", 1, 32'(tc[1]), 32'd1);
        step(0, 1, 4'hE, 0, 1);
        step(0, 0, 4'h0, 1, 1);
        chk("sat_first_tc", 0, 32'(tc[0]), 32'd1);
        chk("sat_first_sat", 0, 32'(sat[0]), 32'd1);
        step(0, 0, 4'h0, 1, 1);
        step(0, 0, 4'h0, 1, 1);
        chk("sat_hold_bin", 0, 32'(bin[0]), 32'd15);
        chk("sat_hold_tc", 0, 32'(tc[0]), 32'd0);
        step(0, 0, 4'h0, 1, 0);
        chk("sat_leave_bin", 0, 32'(bin[0]), 32'd14);
        chk("sat_leave_sat", 0, 32'(sat[0]), 32'd0);
        step(0, 1, 4'h5, 1, 1);
        chk("prio_bin", 1, 32'(bin[1]), 32'd5);
        chk("prio_gray", 1, 32'(gray[1]), 32'b0111);
        step(1, 0, 4'h0, 1, 1);
        chk("prio_rst", 1, 32'(bin[1]), 32'd0);
        step(0, 0, 4'h0, 1, 1);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0, 4'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom));
`ifdef GRAY_CHECK_EN
        step(1, 0, 4'h0, 0, 0);
        repeat (16) step(0, 0, 4'h0, 1, 1);
        fg = gray[1] ^ 4'b0011;
        force u1.gray_q = fg;
        en = 1'b0;
        @(posedge clk);
        #1;
        release u1.gray_q;
        chk("gerr_set", 1, 32'(gerr[1]), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("gerr_sticky", 1, 32'(gerr[1]), 32'd1);
        step(1, 0, 4'h0, 0, 0);
        chk("gerr_rst", 1, 32'(gerr[1]), 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
